// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes, datapath select codes and trap causes for ctrl_fsm_ext.
// The SYSTEM_CSR_EN macro adds the EXEC_SYS/SYSWB states to the state enum.
package ctrl_pkg;
  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_JAL, S_JALR, S_BRANCH, S_LUI, S_AUIPC,
    S_EXEC_MD, S_MDWB, S_TRAP
`ifdef SYSTEM_CSR_EN
    , S_EXEC_SYS, S_SYSWB
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int SRCA_WIDTH   = 2;
  localparam int SRCB_WIDTH   = 2;
  localparam int ALU_OP_WIDTH = 2;
  localparam int RESULT_WIDTH = 3;

  localparam logic [SRCA_WIDTH-1:0] SRCA_PC    = 2'd0;
  localparam logic [SRCA_WIDTH-1:0] SRCA_OLDPC = 2'd1;
  localparam logic [SRCA_WIDTH-1:0] SRCA_RD1   = 2'd2;
  localparam logic [SRCA_WIDTH-1:0] SRCA_ZERO  = 2'd3;

  localparam logic [SRCB_WIDTH-1:0] SRCB_RD2  = 2'd0;
  localparam logic [SRCB_WIDTH-1:0] SRCB_IMM  = 2'd1;
  localparam logic [SRCB_WIDTH-1:0] SRCB_FOUR = 2'd2;

  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_ADD   = 2'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_SUB   = 2'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [RESULT_WIDTH-1:0] RESULT_ALUOUT    = 3'd0;
  localparam logic [RESULT_WIDTH-1:0] RESULT_DATA      = 3'd1;
  localparam logic [RESULT_WIDTH-1:0] RESULT_ALURESULT = 3'd2;
  localparam logic [RESULT_WIDTH-1:0] RESULT_TRAPVEC   = 3'd3;
  localparam logic [RESULT_WIDTH-1:0] RESULT_CSR       = 3'd4;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  // Loads, JALR, I-type and SYSTEM all share the I format (the fallthrough).
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    return op == OP_STORE ? IMM_S :
           op == OP_BRANCH ? IMM_B :
           op == OP_JAL ? IMM_J :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
  endfunction
endpackage

// File: rtl/ctrl_bus_watchdog.sv
// ctrl_bus_watchdog: counts bus wait cycles of one access and flags expiry at BUS_TIMEOUT.
// Ports: clk, resetn (async active-low), wait_i (mem_valid & !mem_ready in a counted state),
// clr_i (FSM state change), expire_o (this wait cycle is the BUS_TIMEOUT-th one).
module ctrl_bus_watchdog #(
  parameter int BUS_TIMEOUT = 255,
  parameter int TO_W        = $clog2(BUS_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic wait_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int CW = TO_W < 1 ? 1 : TO_W;
  localparam bit EN = BUS_TIMEOUT != 0;
  localparam logic [CW-1:0] LAST = CW'(BUS_TIMEOUT == 0 ? 0 : BUS_TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // cnt_q holds the number of earlier wait cycles, so the current wait is the last one at LAST.
  assign cnt_d = (clr_i || !wait_i || !EN) ? '0 : cnt_q + CW'(1);
  assign expire_o = EN && wait_i && cnt_q == LAST;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ctrl_fsm_ext.sv
// ctrl_fsm_ext: multicycle RV32 control FSM with mul/div dispatch, bus watchdog and TRAP state.
// Inputs: clk, resetn (async active-low), op/funct3/funct7b1/instr20 (instruction fields), Zero,
// mem_ready, alu_ready, md_ready. Outputs: mem_valid, alu_valid, md_valid handshakes, datapath
// strobes and selects (AdrSrc..ImmSrc), trap_valid/trap_cause. Define SYSTEM_CSR_EN to add the
// CSR path and ECALL/EBREAK traps; otherwise every SYSTEM opcode traps as illegal.
module ctrl_fsm_ext
  import ctrl_pkg::*;
#(
  parameter int HAS_MULDIV  = 1,
  parameter int BUS_TIMEOUT = 255,
  parameter int TO_W        = $clog2(BUS_TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic                    funct7b1,
  input  logic                    instr20,
  input  logic                    Zero,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    alu_valid,
  input  logic                    alu_ready,
  output logic                    md_valid,
  input  logic                    md_ready,
  output logic                    AdrSrc,
  output logic                    IRWrite,
  output logic                    PCUpdate,
  output logic                    Branch,
  output logic                    RegWrite,
  output logic                    MemWrite,
  output logic                    ALUOutWrite,
  output logic [SRCA_WIDTH-1:0]   ALUSrcA,
  output logic [SRCB_WIDTH-1:0]   ALUSrcB,
  output logic [ALU_OP_WIDTH-1:0] ALUOp,
  output logic [RESULT_WIDTH-1:0] ResultSrc,
  output logic [2:0]              ImmSrc,
  output logic                    trap_valid,
  output logic [3:0]              trap_cause
);
  state_e     state_q, state_d, dec_state;
  logic [3:0] cause_q, cause_d, dec_cause;
  logic       mv, wait_bus, expire;

  assign wait_bus = mv && !mem_ready && (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE});

  ctrl_bus_watchdog #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk      (clk),
    .resetn   (resetn),
    .wait_i   (wait_bus),
    .clr_i    (state_d != state_q),
    .expire_o (expire)
  );

  always_comb begin
    dec_state = S_TRAP;
    dec_cause = CAUSE_ILLEGAL;
    case (op)
      OP_LOAD, OP_STORE: dec_state = S_MEMADDR;
      OP_R:              dec_state = !funct7b1 ? S_EXEC_R : HAS_MULDIV != 0 ? S_EXEC_MD : S_TRAP;
      OP_I:              dec_state = S_EXEC_I;
      OP_JAL:            dec_state = S_JAL;
      OP_JALR:           dec_state = S_JALR;
      OP_BRANCH:         dec_state = S_BRANCH;
      OP_LUI:            dec_state = S_LUI;
      OP_AUIPC:          dec_state = S_AUIPC;
`ifdef SYSTEM_CSR_EN
      OP_SYSTEM: begin
        dec_state = funct3 != 3'd0 ? S_EXEC_SYS : S_TRAP;
        dec_cause = instr20 ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
      end
`endif
      default: ;
    endcase
  end

`ifndef SYSTEM_CSR_EN
  logic unused_sys;
  assign unused_sys = ^{funct3, instr20};
`endif

  // mem_ready wins over expiry because expire only fires on a genuine wait cycle.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : expire ? S_TRAP : S_FETCH;
      S_DECODE:   state_d = alu_ready ? dec_state : S_DECODE;
      S_MEMADDR:  state_d = !alu_ready ? S_MEMADDR : op == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : expire ? S_TRAP : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : expire ? S_TRAP : S_MEMWRITE;
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL: state_d = alu_ready ? S_ALUWB : state_q;
      S_JALR:     state_d = alu_ready ? S_JAL : S_JALR;
      S_BRANCH:   state_d = alu_ready ? S_FETCH : S_BRANCH;
      S_EXEC_MD:  state_d = md_ready ? S_MDWB : S_EXEC_MD;
`ifdef SYSTEM_CSR_EN
      S_EXEC_SYS: state_d = alu_ready ? S_SYSWB : S_EXEC_SYS;
`endif
      default:    state_d = S_FETCH;
    endcase
    if (state_d == S_TRAP && state_q != S_TRAP)
      cause_d = state_q == S_DECODE ? dec_cause :
                state_q == S_MEMREAD ? CAUSE_LOAD_FAULT :
                state_q == S_MEMWRITE ? CAUSE_STORE_FAULT : CAUSE_IFETCH_FAULT;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_FETCH;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end

  // Strobes decode from the registered state; resetn gates them so they drop the moment reset asserts.
  always_comb begin
    mv          = 1'b0;
    alu_valid   = 1'b0;
    md_valid    = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCUpdate    = 1'b0;
    Branch      = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    ALUSrcA     = SRCA_RD1;
    ALUSrcB     = SRCB_IMM;
    ALUOp       = ALUOP_ADD;
    ResultSrc   = RESULT_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mv        = 1'b1;
        IRWrite   = mem_ready;
        alu_valid = mem_ready;
        PCUpdate  = alu_ready;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RESULT_ALURESULT;
      end
      S_DECODE, S_AUIPC: begin
        alu_valid = 1'b1;
        ALUSrcA   = SRCA_OLDPC;
      end
      S_MEMADDR, S_JALR: alu_valid = 1'b1;
      S_MEMREAD: begin
        mv     = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        mv       = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RESULT_DATA;
      end
      S_EXEC_R: begin
        alu_valid = 1'b1;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_valid = 1'b1;
        ALUOp     = ALUOP_FUNCT;
      end
      S_LUI: begin
        alu_valid = 1'b1;
        ALUSrcA   = SRCA_ZERO;
      end
      S_JAL: begin
        alu_valid = 1'b1;
        PCUpdate  = 1'b1;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
      end
      S_BRANCH: begin
        mv        = Zero;
        alu_valid = 1'b1;
        Branch    = 1'b1;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = ALUOP_SUB;
      end
      S_ALUWB, S_MDWB: RegWrite = 1'b1;
      S_EXEC_MD: begin
        md_valid = 1'b1;
        ALUSrcB  = SRCB_RD2;
      end
`ifdef SYSTEM_CSR_EN
      S_EXEC_SYS: begin
        alu_valid = 1'b1;
        ALUOp     = ALUOP_FUNCT;
      end
      S_SYSWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RESULT_CSR;
      end
`endif
      S_TRAP: begin
        PCUpdate  = 1'b1;
        ResultSrc = RESULT_TRAPVEC;
      end
      default: ;
    endcase
    mem_valid   = mv;
    ALUOutWrite = state_q == S_EXEC_MD ? md_ready : !mv;
    trap_valid  = state_q == S_TRAP;
    if (!resetn) begin
      mem_valid   = 1'b0;
      alu_valid   = 1'b0;
      md_valid    = 1'b0;
      AdrSrc      = 1'b0;
      IRWrite     = 1'b0;
      PCUpdate    = 1'b0;
      Branch      = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      ALUOutWrite = 1'b0;
      trap_valid  = 1'b0;
    end
  end

  assign trap_cause = trap_valid ? cause_q : 4'd0;
  assign ImmSrc     = imm_src(op);
endmodule

// File: tb/tb_ctrl_fsm_ext.sv
// tb_ctrl_fsm_ext: directed vectors for ctrl_fsm_ext (BUS_TIMEOUT=4) plus a HAS_MULDIV=0 instance.
module tb_ctrl_fsm_ext;
  import ctrl_pkg::*;
  logic clk = 1'b0, resetn = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b1 = 1'b0, instr20 = 1'b0, Zero = 1'b0;
  logic mem_ready = 1'b0, alu_ready = 1'b0, md_ready = 1'b0;
  logic mem_valid, alu_valid, md_valid, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic ALUOutWrite, trap_valid;
  logic [SRCA_WIDTH-1:0] ALUSrcA;
  logic [SRCB_WIDTH-1:0] ALUSrcB;
  logic [ALU_OP_WIDTH-1:0] ALUOp;
  logic [RESULT_WIDTH-1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] trap_cause;
  logic nm_mem_valid, nm_alu_valid, nm_md_valid, nm_AdrSrc, nm_IRWrite, nm_PCUpdate, nm_Branch;
  logic nm_RegWrite, nm_MemWrite, nm_ALUOutWrite, nm_trap_valid;
  logic [SRCA_WIDTH-1:0] nm_ALUSrcA;
  logic [SRCB_WIDTH-1:0] nm_ALUSrcB;
  logic [ALU_OP_WIDTH-1:0] nm_ALUOp;
  logic [RESULT_WIDTH-1:0] nm_ResultSrc;
  logic [2:0] nm_ImmSrc;
  logic [3:0] nm_trap_cause;
  int cmp_cnt = 0, err_cnt = 0;

  // strobe vector: {mem_valid, alu_valid, md_valid, AdrSrc, IRWrite, PCUpdate, Branch,
  //                 RegWrite, MemWrite, ALUOutWrite, trap_valid}
  localparam logic [10:0] V_OFF   = 11'h000;
  localparam logic [10:0] V_FWAIT = 11'h400;
  localparam logic [10:0] V_FRDY  = 11'h660;
  localparam logic [10:0] V_ALU   = 11'h202;
  localparam logic [10:0] V_WB    = 11'h00A;
  localparam logic [10:0] V_MDW   = 11'h100;
  localparam logic [10:0] V_MDR   = 11'h102;
  localparam logic [10:0] V_TRAP  = 11'h023;
  localparam logic [10:0] V_MEMRD = 11'h480;
  localparam logic [10:0] V_MEMWR = 11'h484;
  localparam logic [10:0] V_BR    = 11'h610;

  ctrl_fsm_ext #(.HAS_MULDIV(1), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b1(funct7b1), .instr20(instr20),
    .Zero(Zero), .mem_valid(mem_valid), .mem_ready(mem_ready), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .md_valid(md_valid), .md_ready(md_ready), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUOutWrite(ALUOutWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .trap_valid(trap_valid),
    .trap_cause(trap_cause)
  );

  ctrl_fsm_ext #(.HAS_MULDIV(0), .BUS_TIMEOUT(4)) dut_nm (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b1(funct7b1), .instr20(instr20),
    .Zero(Zero), .mem_valid(nm_mem_valid), .mem_ready(mem_ready), .alu_valid(nm_alu_valid),
    .alu_ready(alu_ready), .md_valid(nm_md_valid), .md_ready(md_ready), .AdrSrc(nm_AdrSrc),
    .IRWrite(nm_IRWrite), .PCUpdate(nm_PCUpdate), .Branch(nm_Branch), .RegWrite(nm_RegWrite),
    .MemWrite(nm_MemWrite), .ALUOutWrite(nm_ALUOutWrite), .ALUSrcA(nm_ALUSrcA),
    .ALUSrcB(nm_ALUSrcB), .ALUOp(nm_ALUOp), .ResultSrc(nm_ResultSrc), .ImmSrc(nm_ImmSrc),
    .trap_valid(nm_trap_valid), .trap_cause(nm_trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [10:0] sb();
    return {mem_valid, alu_valid, md_valid, AdrSrc, IRWrite, PCUpdate, Branch,
            RegWrite, MemWrite, ALUOutWrite, trap_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic i20);
    op = o;
    funct3 = f3;
    funct7b1 = f7;
    instr20 = i20;
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      #1 chk("fetch_wait", sb(), V_FWAIT);
      tick();
    end
    mem_ready = 1'b1;
    alu_ready = 1'b1;
    #1 chk("fetch_rdy", sb(), V_FRDY);
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic decode();
    #1 chk("decode", sb(), V_ALU);
    chk("decode_srca", ALUSrcA, SRCA_OLDPC);
    tick();
  endtask

  initial begin
    int n;
    #1 chk("reset_strobes", sb(), V_OFF);
    chk("reset_cause", trap_cause, 0);
    tick();
    tick();
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("reset_fetch", sb(), V_FWAIT);
    chk("fetch_srcb", ALUSrcB, SRCB_FOUR);
    // ADDI with two fetch waits
    fetch(2, 7'b0010011, 3'd0, 1'b0, 1'b0);
    chk("addi_imm", ImmSrc, 0);
    decode();
    #1 chk("exec_i", sb(), V_ALU);
    chk("exec_i_aluop", ALUOp, ALUOP_FUNCT);
    tick();
    #1 chk("aluwb", sb(), V_WB);
    chk("aluwb_res", ResultSrc, RESULT_ALUOUT);
    tick();
    alu_ready = 1'b0;
    #1 chk("addi_back", sb(), V_FWAIT);
    // MUL with md_ready on the 33rd cycle; the no-muldiv instance traps
    fetch(0, 7'b0110011, 3'd0, 1'b1, 1'b0);
    decode();
    n = 0;
    for (int i = 0; i < 32; i++) begin
      #1 chk("md_wait", sb(), V_MDW);
      n += int'(md_valid);
      if (i == 0) begin
        chk("nm_trap_valid", nm_trap_valid, 1);
        chk("nm_trap_cause", nm_trap_cause, 2);
      end
      tick();
    end
    md_ready = 1'b1;
    #1 chk("md_rdy", sb(), V_MDR);
    n += int'(md_valid);
    chk("md_cycles", n, 33);
    chk("md_srca", ALUSrcA, SRCA_RD1);
    tick();
    md_ready = 1'b0;
    #1 chk("mdwb", sb(), V_WB);
    tick();
    // illegal opcode
    fetch(0, 7'b1111111, 3'd0, 1'b0, 1'b0);
    decode();
    #1 chk("ill_trap", sb(), V_TRAP);
    chk("ill_cause", trap_cause, 2);
    chk("ill_res", ResultSrc, RESULT_TRAPVEC);
    tick();
    alu_ready = 1'b0;
    #1 chk("ill_back", sb(), V_FWAIT);
    // LW timing out after four waits
    fetch(0, 7'b0000011, 3'd2, 1'b0, 1'b0);
    decode();
    #1 chk("memaddr", sb(), V_ALU);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 chk("lw_wait", sb(), V_MEMRD);
      tick();
    end
    #1 chk("lw_trap", sb(), V_TRAP);
    chk("lw_cause", trap_cause, 5);
    tick();
    // LW with mem_ready in the fourth wait cycle
    fetch(0, 7'b0000011, 3'd2, 1'b0, 1'b0);
    decode();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 chk("lw2_wait", sb(), V_MEMRD);
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("lw2_rdy", sb(), V_MEMRD);
    tick();
    mem_ready = 1'b0;
    #1 chk("memwb", sb(), V_WB);
    chk("memwb_res", ResultSrc, RESULT_DATA);
    tick();
    // fetch timing out
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("if_wait", sb(), V_FWAIT);
      tick();
    end
    #1 chk("if_trap", sb(), V_TRAP);
    chk("if_cause", trap_cause, 1);
    tick();
    // taken branch
    fetch(0, 7'b1100011, 3'd0, 1'b0, 1'b0);
    chk("br_imm", ImmSrc, 2);
    decode();
    Zero = 1'b1;
    #1 chk("branch", sb(), V_BR);
    chk("br_aluop", ALUOp, ALUOP_SUB);
    tick();
    Zero = 1'b0;
    // SYSTEM
`ifdef SYSTEM_CSR_EN
    fetch(0, 7'b1110011, 3'd0, 1'b0, 1'b0);
    decode();
    #1 chk("ecall_trap", sb(), V_TRAP);
    chk("ecall_cause", trap_cause, 11);
    tick();
    fetch(0, 7'b1110011, 3'd0, 1'b0, 1'b1);
    decode();
    #1 chk("ebreak_cause", trap_cause, 3);
    tick();
    fetch(0, 7'b1110011, 3'd1, 1'b0, 1'b0);
    decode();
    #1 chk("exec_sys", sb(), V_ALU);
    tick();
    #1 chk("syswb", sb(), V_WB);
    chk("syswb_res", ResultSrc, RESULT_CSR);
    tick();
`else
    fetch(0, 7'b1110011, 3'd1, 1'b0, 1'b0);
    chk("sys_imm", ImmSrc, 0);
    decode();
    #1 chk("csr_trap", sb(), V_TRAP);
    chk("csr_cause", trap_cause, 2);
    tick();
`endif
    // SW interrupted by reset during the bus wait
    fetch(0, 7'b0100011, 3'd2, 1'b0, 1'b0);
    chk("sw_imm", ImmSrc, 1);
    decode();
    tick();
    #1 chk("memwrite", sb(), V_MEMWR);
    tick();
    #2 resetn = 1'b0;
    #1 chk("rst_async", sb(), V_OFF);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    alu_ready = 1'b0;
    #1 chk("rst_fetch", sb(), V_FWAIT);
    chk("rst_srca", ALUSrcA, SRCA_PC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
